// File: rtl/vote_tally_controller.sv
// Ballot controller: arms one vote per officer arm, writes the chosen
// candidate's tally through a 4x4-bit external memory, and zeroes it on clear.
module vote_tally_controller #(
  parameter int unsigned CNT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        session_open,
  input  logic        arm,
  input  logic        clear,
  input  logic [3:0]  vote_btn,
  input  logic [15:0] mem_q,
  output logic [1:0]  mem_sel,
  output logic        mem_we,
  output logic [3:0]  mem_wdata,
  output logic        ready,
  output logic        busy,
  output logic        vote_ack,
  output logic        invalid,
  output logic        sat,
  output logic [5:0]  total_votes
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WRITE,
    RELEASE,
    REJECT,
    CLEAR
  } state_e;

  localparam logic [3:0] LIM = 4'(CNT_MAX);
  localparam logic [5:0] TOT_MAX = 6'd63;

  state_e      state_q;
  logic [1:0]  mem_sel_q;
  logic        mem_we_q;
  logic [3:0]  mem_wdata_q;
  logic        ready_q;
  logic        busy_q;
  logic        vote_ack_q;
  logic        invalid_q;
  logic        sat_q;
  logic [5:0]  total_q;

  logic [2:0]  btn_cnt_d;
  logic [1:0]  btn_idx_d;
  logic [3:0]  tally_d;

  always_comb begin
    btn_cnt_d = 3'(vote_btn[0]) + 3'(vote_btn[1])
              + 3'(vote_btn[2]) + 3'(vote_btn[3]);
  end

  always_comb begin
    btn_idx_d = 2'd0;
    if (btn_cnt_d == 3'd1) begin
      unique case (1'b1)
        vote_btn[0]: btn_idx_d = 2'd0;
        vote_btn[1]: btn_idx_d = 2'd1;
        vote_btn[2]: btn_idx_d = 2'd2;
        vote_btn[3]: btn_idx_d = 2'd3;
      endcase
    end
  end

  assign tally_d = mem_q[{mem_sel_q, 2'b00} +: 4];

  // All outputs registered: the write pulse lands the cycle after WRITE
  // decides, so the tally is captured two edges after the press is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_sel_q   <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 4'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      vote_ack_q  <= 1'b0;
      invalid_q   <= 1'b0;
      sat_q       <= 1'b0;
      total_q     <= 6'd0;
    end else begin
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 4'd0;
      vote_ack_q  <= 1'b0;
      invalid_q   <= 1'b0;
      sat_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clear) begin
            state_q   <= CLEAR;
            mem_sel_q <= 2'd0;
            mem_we_q  <= 1'b1;
            total_q   <= 6'd0;
            busy_q    <= 1'b1;
          end else if (session_open && arm) begin
            state_q <= ARMED;
            ready_q <= 1'b1;
          end
        end
        ARMED: begin
          if (!session_open) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
          end else if (btn_cnt_d == 3'd1) begin
            state_q   <= WRITE;
            mem_sel_q <= btn_idx_d;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end else if (btn_cnt_d > 3'd1) begin
            state_q   <= REJECT;
            invalid_q <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        WRITE: begin
          state_q <= RELEASE;
          busy_q  <= 1'b0;
          if (tally_d < LIM) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= tally_d + 4'd1;
            vote_ack_q  <= 1'b1;
            if (total_q != TOT_MAX) total_q <= total_q + 6'd1;
          end else begin
            sat_q <= 1'b1;
          end
        end
        RELEASE: begin
          if (vote_btn == 4'd0) state_q <= IDLE;
        end
        REJECT: begin
          if (vote_btn == 4'd0) begin
            state_q <= ARMED;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        CLEAR: begin
          if (mem_sel_q == 2'd3) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            mem_sel_q <= mem_sel_q + 2'd1;
            mem_we_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_sel     = mem_sel_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign vote_ack    = vote_ack_q;
  assign invalid     = invalid_q;
  assign sat         = sat_q;
  assign total_votes = total_q;

endmodule

// File: tb/tb_vote_tally_controller.sv
// Directed plus randomized ballots against a tally-level reference model,
// with a small behavioural memory standing in for the four tally blocks.
module tb_vote_tally_controller;

  logic        clk;
  logic        rst_n;
  logic        session_open;
  logic        arm;
  logic        clear;
  logic [3:0]  vote_btn;
  logic [15:0] mem_q;
  logic [1:0]  mem_sel;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic        ready;
  logic        busy;
  logic        vote_ack;
  logic        invalid;
  logic        sat;
  logic [5:0]  total_votes;

  vote_tally_controller #(.CNT_MAX(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .session_open(session_open),
    .arm         (arm),
    .clear       (clear),
    .vote_btn    (vote_btn),
    .mem_q       (mem_q),
    .mem_sel     (mem_sel),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .ready       (ready),
    .busy        (busy),
    .vote_ack    (vote_ack),
    .invalid     (invalid),
    .sat         (sat),
    .total_votes (total_votes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] mem [4];
  logic       bd_en;
  logic [1:0] bd_k;
  logic [3:0] bd_v;

  always @(posedge clk) begin
    if (mem_we) mem[mem_sel] <= mem_wdata;
    else if (bd_en) mem[bd_k] <= bd_v;
  end

  assign mem_q = {mem[3], mem[2], mem[1], mem[0]};

  int ref_tally [4];
  int ref_total;
  int total;
  int bad;
  int n_we, n_ack, n_sat, n_inv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input int k, input int v);
    bd_en = 1'b1;
    bd_k  = 2'(k);
    bd_v  = 4'(v);
    step();
    bd_en = 1'b0;
    ref_tally[k] = v;
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 4; k++)
      chk({tag, "_tally"}, 32'(mem_q[4*k +: 4]), 32'(ref_tally[k]));
    chk({tag, "_total"}, 32'(total_votes), 32'(ref_total));
  endtask

  task automatic hold(input int n);
    n_we = 0; n_ack = 0; n_sat = 0; n_inv = 0;
    repeat (n) begin
      step();
      n_we  += int'(mem_we);
      n_ack += int'(vote_ack);
      n_sat += int'(sat);
      n_inv += int'(invalid);
    end
  endtask

  // One-hot press from ARMED, held then released; model decides the outcome.
  task automatic press_one(input int k, input string tag);
    vote_btn = 4'b0001 << k;
    hold(4);
    vote_btn = 4'd0;
    step();
    if (ref_tally[k] < 15) begin
      chk({tag, "_ack"}, 32'(n_ack), 32'd1);
      chk({tag, "_we"}, 32'(n_we), 32'd1);
      ref_tally[k]++;
      if (ref_total < 63) ref_total++;
    end else begin
      chk({tag, "_sat"}, 32'(n_sat), 32'd1);
      chk({tag, "_we0"}, 32'(n_we), 32'd0);
    end
    chk({tag, "_idle"}, 32'({ready, busy}), 32'd0);
  endtask

  task automatic arm_ballot(input string tag);
    session_open = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  function automatic logic [3:0] multi_btn();
    logic [3:0] v;
    do v = 4'($urandom_range(3, 15));
    while (v == 4'd4 || v == 4'd8);
    return v;
  endfunction

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; session_open = 1'b0; arm = 1'b0; clear = 1'b0;
    vote_btn = 4'd0; bd_en = 1'b0; bd_k = 2'd0; bd_v = 4'd0;
    for (int k = 0; k < 4; k++) ref_tally[k] = 0;
    ref_total = 0;
    step(); step();
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_sel", 32'(mem_sel), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_flags", 32'({ready, busy, vote_ack, invalid, sat}), 32'd0);
    chk("rst_total", 32'(total_votes), 32'd0);
    rst_n = 1'b1;
    step();

    // Clear sweep, with arm asserted too to show clear wins.
    clear = 1'b1; session_open = 1'b1; arm = 1'b1;
    step();
    clear = 1'b0; arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("clr_we", 32'(mem_we), 32'd1);
      chk("clr_sel", 32'(mem_sel), 32'(i));
      chk("clr_wdata", 32'(mem_wdata), 32'd0);
      chk("clr_busy", 32'(busy), 32'd1);
      step();
    end
    chk("clr_end_we", 32'(mem_we), 32'd0);
    chk("clr_end_st", 32'({ready, busy}), 32'd0);
    check_model("clr");

    // Latency and values of a single vote on candidate 2.
    backdoor(2, 3);
    arm_ballot("v2");
    vote_btn = 4'b0100;
    step();
    chk("v2_sel", 32'(mem_sel), 32'd2);
    chk("v2_we_early", 32'(mem_we), 32'd0);
    step();
    chk("v2_we", 32'(mem_we), 32'd1);
    chk("v2_wdata", 32'(mem_wdata), 32'd4);
    chk("v2_ack", 32'(vote_ack), 32'd1);
    chk("v2_total", 32'(total_votes), 32'd1);
    step();
    chk("v2_we_off", 32'(mem_we), 32'd0);
    step();
    chk("v2_release", 32'({ready, mem_we}), 32'd0);
    vote_btn = 4'd0;
    step();
    ref_tally[2] = 4; ref_total = 1;
    check_model("v2");

    // Multi-press: one invalid pulse, ballot retained, then a good vote.
    arm_ballot("inv");
    vote_btn = 4'b0011;
    hold(5);
    chk("inv_pulses", 32'(n_inv), 32'd1);
    chk("inv_we", 32'(n_we), 32'd0);
    chk("inv_busy", 32'(busy), 32'd1);
    vote_btn = 4'd0;
    step();
    chk("inv_rearm", 32'(ready), 32'd1);
    vote_btn = 4'b0001;
    step(); step();
    chk("inv_w_we", 32'(mem_we), 32'd1);
    chk("inv_w_sel", 32'(mem_sel), 32'd0);
    vote_btn = 4'd0;
    step();
    ref_tally[0]++; ref_total++;
    check_model("inv");

    // Saturated tally refuses the vote.
    backdoor(0, 15);
    arm_ballot("sat");
    press_one(0, "sat");
    check_model("sat");

    // Session drop cancels the ballot; arm without session does nothing.
    arm_ballot("cx");
    session_open = 1'b0;
    step();
    chk("cx_ready", 32'(ready), 32'd0);
    arm = 1'b1;
    step(); step();
    chk("cx_noarm", 32'(ready), 32'd0);
    arm = 1'b0;
    vote_btn = 4'b0010;
    hold(3);
    vote_btn = 4'd0;
    chk("cx_nowe", 32'(n_we), 32'd0);
    check_model("cx");

    // Reset in the middle of a clear sweep.
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    chk("rc_sel1", 32'(mem_sel), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rc_we", 32'(mem_we), 32'd0);
    chk("rc_sel", 32'(mem_sel), 32'd0);
    chk("rc_flags", 32'({ready, busy, vote_ack, invalid, sat}), 32'd0);
    chk("rc_total", 32'(total_votes), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 4; k++) ref_tally[k] = 0;
    ref_total = 0;
    check_model("rc");

    // Random ballots; occasional backdoor tally reloads let the running
    // total climb past 63 and exercise both saturation limits.
    for (int it = 0; it < 140; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0)
        backdoor($urandom_range(0, 3), $urandom_range(0, 15));
      arm_ballot("rnd");
      if (sel == 0) begin
        session_open = 1'b0;
        step();
        chk("rnd_cancel", 32'(ready), 32'd0);
      end else begin
        if (sel < 3) begin
          vote_btn = multi_btn();
          hold(3);
          vote_btn = 4'd0;
          chk("rnd_inv", 32'(n_inv), 32'd1);
          chk("rnd_inv_we", 32'(n_we), 32'd0);
          step();
        end
        press_one($urandom_range(0, 3), "rnd");
      end
      check_model("rnd");
    end
    chk("rnd_total_sat", 32'(ref_total == 63 || total_votes < 6'd63), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vote_tally_controller.md
VOTE_TALLY_CONTROLLER -- requirements
Module: vote_tally_controller

Interface
REQ-001 SHALL have parameter CNT_MAX, default 15, saturation value of each 4-bit candidate counter (1..15).
REQ-002 SHALL have one clock and an asynchronous active-low reset.
REQ-003 SHALL have ports, in order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- session_open  in  1  polling session enabled.
- arm  in  1  officer ballot-issue pulse/level.
- clear  in  1  request zeroing of all tallies.
- vote_btn  in  4  candidate buttons, pre-debounced, synchronous to clk.
- mem_q  in  16  current tallies, candidate k at bits [4k+3:4k].
- mem_sel  out  2  candidate block addressed.
- mem_we  out  1  write enable to the addressed block.
- mem_wdata  out  4  data written to the addressed block.
- ready  out  1  ballot armed, voter may press.
- busy  out  1  high in WRITE, CLEAR or REJECT.
- vote_ack  out  1  one-cycle pulse, vote recorded.
- invalid  out  1  one-cycle pulse, multiple buttons pressed.
- sat  out  1  one-cycle pulse, vote refused because the tally is at CNT_MAX.
- total_votes  out  6  votes recorded since the last clear.
REQ-004 SHALL drive mem_we only for a single cycle per write; the external memory blocks capture on the same clk edge.

Function
REQ-005 SHALL implement states IDLE, ARMED, WRITE, RELEASE, REJECT, CLEAR.
REQ-006 IDLE: clear=1 -> CLEAR; else session_open=1 and arm=1 -> ARMED; clear has priority over arm.
REQ-007 ARMED: ready=1; session_open=0 -> IDLE (ballot cancelled, no write); vote_btn with exactly one bit set -> WRITE, latching the index into mem_sel; two or more bits set -> REJECT with invalid=1 on the transition cycle; vote_btn=0 -> stay.
REQ-008 WRITE (one cycle): if mem_q[mem_sel] < CNT_MAX, then mem_we=1, mem_wdata=mem_q[mem_sel]+1, vote_ack=1 and total_votes increments; else mem_we=0 and sat=1. Next state RELEASE in both cases; the ballot is consumed.
REQ-009 RELEASE: wait until vote_btn=0, then -> IDLE; a new arm is required for the next voter.
REQ-010 REJECT: wait until vote_btn=0, then -> ARMED (ballot retained); invalid SHALL NOT re-pulse while buttons are held.
REQ-011 CLEAR: four consecutive cycles with mem_sel=0,1,2,3, mem_we=1 and mem_wdata=0; total_votes <= 0 on entry; -> IDLE after sel 3; arm and vote_btn are ignored.
REQ-012 Latency: one-hot press sampled in ARMED at edge n; mem_we high during cycle n+1; the tally is updated at edge n+2.
REQ-013 total_votes SHALL saturate at 63 and never wrap.
REQ-014 arm, clear or vote_btn SHALL be ignored in any state not listed as consuming it; session_open falling in WRITE or CLEAR SHALL NOT abort that state.
REQ-015 Outside WRITE/CLEAR writes, mem_we=0, mem_wdata=0 and mem_sel holds its last value.

Reset
REQ-016 rst_n=0 SHALL immediately force state IDLE, mem_we=0, mem_sel=0, mem_wdata=0, ready=0, busy=0, vote_ack=0, invalid=0, sat=0, total_votes=0.
REQ-017 Reset mid-WRITE or mid-CLEAR SHALL abort with no further writes. The memory blocks have no reset, so CLEAR is required after power-up before tallies are valid.

Verification
REQ-018 Reset, clear -> mem_we on 4 cycles with sel 0..3 and wdata 0, then IDLE; total_votes=0.
REQ-019 session_open=1, arm, vote_btn=4'b0100 with mem_q[11:8]=3 -> one cycle later mem_sel=2, mem_we=1, mem_wdata=4, vote_ack=1, total_votes=1; RELEASE until the button is released.
REQ-020 In ARMED, vote_btn=4'b0011 held 5 cycles -> a single invalid pulse, no mem_we; release, then 4'b0001 -> write to sel 0.
REQ-021 mem_q[3:0]=15 and vote on candidate 0 -> sat=1, mem_we=0, total_votes unchanged, returns to IDLE after release.
REQ-022 In ARMED, drop session_open -> IDLE, ready=0, no write; arm asserted with session_open=0 -> stays IDLE.
REQ-023 Assert rst_n=0 during CLEAR at sel 1 -> mem_we low immediately; after release all outputs are at reset values.
